// File: rtl/seg_dynamic_disp.sv
// Six-digit multiplexed common-anode seven-segment driver with sequential binary-to-BCD conversion.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module seg_dynamic_disp #(
   parameter logic [15:0] CNT_MAX = 16'd49_999
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic [19:0] data,
   input  logic [5:0]  point,
   input  logic        seg_en,
   input  logic        sign,
   output logic [5:0]  sel,
   output logic [7:0]  seg
);

   localparam int unsigned BIN_W   = 20;
   localparam int unsigned BCD_W   = 24;
   localparam int unsigned DIG_N   = 6;
   localparam int unsigned SHIFT_N = 20;
   localparam int unsigned SCNT_W  = 5;
   localparam int unsigned IDX_W   = 3;

   localparam logic [BIN_W-1:0] DATA_MAX = 20'd999_999;
   localparam logic [7:0]       BLANK    = 8'hFF;
   localparam logic [7:0]       MINUS    = 8'hBF;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] LOAD  = 2'd2;

   logic [1:0]                state;
   logic [1:0]                state_nxt;
   logic [SCNT_W-1:0]         shift_cnt;
   logic [BIN_W-1:0]          bin_reg;
   logic [BCD_W-1:0]          bcd_reg;
   logic [BCD_W-1:0]          bcd_adj;
   logic [DIG_N-1:0]          point_lat;
   logic                      sign_lat;
   logic [DIG_N-1:0][3:0]     disp_dig;
   logic [DIG_N-1:0]          disp_point;
   logic                      disp_sign;
   logic [15:0]               scan_cnt;
   logic [IDX_W-1:0]          idx;
   logic [3:0]                cur_dig;
   logic [7:0]                base_code;
   logic [7:0]                seg_code_c;

   function automatic logic [7:0] digit_code(input logic [3:0] d);
      case (d)
         4'd0:    digit_code = 8'hC0;
         4'd1:    digit_code = 8'hF9;
         4'd2:    digit_code = 8'hA4;
         4'd3:    digit_code = 8'hB0;
         4'd4:    digit_code = 8'h99;
         4'd5:    digit_code = 8'h92;
         4'd6:    digit_code = 8'h82;
         4'd7:    digit_code = 8'hF8;
         4'd8:    digit_code = 8'h80;
         4'd9:    digit_code = 8'h90;
         default: digit_code = BLANK;
      endcase
   endfunction

   // Conversion FSM state register
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state <= IDLE;
      else            state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = SHIFT;
         SHIFT:   if (shift_cnt == SCNT_W'(SHIFT_N - 1)) state_nxt = LOAD;
         LOAD:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Double-dabble correction: nibbles of 5 or more get +3 before the shift
   always_comb begin
      bcd_adj = bcd_reg;
      for (int unsigned i = 0; i < DIG_N; i++) begin
         if (bcd_reg[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_reg[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         shift_cnt  <= '0;
         bin_reg    <= '0;
         bcd_reg    <= '0;
         point_lat  <= '0;
         sign_lat   <= 1'b0;
         disp_dig   <= '0;
         disp_point <= '0;
         disp_sign  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bin_reg   <= (data > DATA_MAX) ? DATA_MAX : data;
               bcd_reg   <= '0;
               point_lat <= point;
               sign_lat  <= sign;
               shift_cnt <= '0;
            end
            SHIFT: begin
               {bcd_reg, bin_reg} <= (BCD_W + BIN_W)'({bcd_adj, bin_reg} << 1);
               shift_cnt          <= shift_cnt + SCNT_W'(1);
            end
            LOAD: begin
               disp_dig   <= bcd_reg;
               disp_point <= point_lat;
               disp_sign  <= sign_lat;
            end
            default: ;
         endcase
      end
   end

   // Digit scan: dwell of CNT_MAX+1 clocks per digit
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         scan_cnt <= '0;
         idx      <= '0;
      end else if (scan_cnt == CNT_MAX) begin
         scan_cnt <= '0;
         idx      <= (idx == IDX_W'(DIG_N - 1)) ? '0 : idx + IDX_W'(1);
      end else begin
         scan_cnt <= scan_cnt + 16'd1;
      end
   end

   assign cur_dig = disp_dig[idx];

`ifdef SEG_LZB_EN
   logic [IDX_W-1:0] hi_nz;

   // Digit 0 is always significant, so an all-zero value still shows "0"
   always_comb begin
      hi_nz = '0;
      for (int unsigned i = 1; i < DIG_N; i++) begin
         if (disp_dig[i] != 4'd0) hi_nz = IDX_W'(i);
      end
   end

   always_comb begin
      base_code = digit_code(cur_dig);
      if (idx > hi_nz) begin
         base_code = (disp_sign && (idx == hi_nz + IDX_W'(1))) ? MINUS : BLANK;
      end
   end
`else
   always_comb begin
      base_code = digit_code(cur_dig);
      if (disp_sign && (idx == IDX_W'(DIG_N - 1))) base_code = MINUS;
   end
`endif

   assign seg_code_c = {base_code[7] & ~disp_point[idx], base_code[6:0]};

   // Registered pin drive; disable only masks the pins
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sel <= 6'h3F;
         seg <= BLANK;
      end else if (seg_en) begin
         sel <= ~(6'd1 << idx);
         seg <= seg_code_c;
      end else begin
         sel <= 6'h3F;
         seg <= BLANK;
      end
   end

endmodule

// File: tb/tb_seg_dynamic_disp.sv
// Scoreboard bench for seg_dynamic_disp: expected digit codes are computed from decimal
// arithmetic and checked by a monitor that watches the scanned pins.
module tb_seg_dynamic_disp;

   localparam logic [15:0] CNT_MAX = 16'd4;
   localparam int          DWELL   = 5;
   localparam int          SETTLE  = 50;

   typedef struct packed {
      logic            en;
      logic [5:0][7:0] codes;
   } item_t;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n;
   logic [19:0] data;
   logic [5:0]  point;
   logic        seg_en;
   logic        sign;
   logic [5:0]  sel;
   logic [7:0]  seg;

   item_t sb[$];
   int    tests    = 0;
   int    fails    = 0;
   int    push_cnt = 0;
   int    done_cnt = 0;

   seg_dynamic_disp #(.CNT_MAX(CNT_MAX)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .data      (data),
      .point     (point),
      .seg_en    (seg_en),
      .sign      (sign),
      .sel       (sel),
      .seg       (seg)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] lut(input int d);
      case (d)
         0: lut = 8'hC0;  1: lut = 8'hF9;  2: lut = 8'hA4;  3: lut = 8'hB0;  4: lut = 8'h99;
         5: lut = 8'h92;  6: lut = 8'h82;  7: lut = 8'hF8;  8: lut = 8'h80;  default: lut = 8'h90;
      endcase
   endfunction

   // Reference: decimal digits by division, then blanking/sign/dp rules
   function automatic logic [5:0][7:0] ref_codes(input logic [19:0] d, input logic [5:0] p,
                                                 input logic s);
      logic [5:0][7:0] r;
      int v;
      int p10;
      int dig[6];
      int hi;
      v   = (int'(d) > 999999) ? 999999 : int'(d);
      p10 = 1;
      hi  = 0;
      for (int i = 0; i < 6; i++) begin
         dig[i] = (v / p10) % 10;
         p10    = p10 * 10;
         if (dig[i] != 0) hi = i;
      end
      for (int i = 0; i < 6; i++) begin
`ifdef SEG_LZB_EN
         if (i > hi) r[i] = (s && i == hi + 1) ? 8'hBF : 8'hFF;
         else        r[i] = lut(dig[i]);
`else
         r[i] = (s && i == 5) ? 8'hBF : lut(dig[i]);
`endif
         if (p[i]) r[i][7] = 1'b0;
      end
      return r;
   endfunction

   task automatic wait_done();
      int n = 0;
      while (done_cnt < push_cnt && n < 200) begin
         @(posedge sys_clk);
         n++;
      end
      if (done_cnt < push_cnt) begin
         tests++;
         fails++;
         $display("FAIL monitor_timeout: got done=%0d expected %0d", done_cnt, push_cnt);
      end
   endtask

   task automatic push_item(input logic en, input logic [5:0][7:0] codes);
      item_t it;
      it.en    = en;
      it.codes = codes;
      sb.push_back(it);
      push_cnt++;
      wait_done();
   endtask

   task automatic run_item(input logic [19:0] d, input logic [5:0] p, input logic s);
      @(negedge sys_clk);
      data  = d;
      point = p;
      sign  = s;
      repeat (SETTLE) @(posedge sys_clk);
      push_item(1'b1, ref_codes(d, p, s));
   endtask

   // Monitor: checks every sampled cycle against the popped expectation
   initial begin
      item_t       it;
      int          prev;
      int          run;
      int          dig;
      bit          first_run;
      logic [5:0]  seen;
      logic [5:0]  oh;
      forever begin
         while (sb.size() == 0) @(posedge sys_clk);
         it = sb.pop_front();
         repeat (2) @(posedge sys_clk);
         prev      = -1;
         run       = 0;
         first_run = 1'b1;
         seen      = '0;
         for (int c = 0; c < 32; c++) begin
            @(negedge sys_clk);
            if (!it.en) begin
               check("off_sel", 32'(sel), 32'h3F);
               check("off_seg", 32'(seg), 32'hFF);
            end else begin
               dig = -1;
               for (int i = 0; i < 6; i++) begin
                  oh = ~(6'd1 << i);
                  if (sel == oh) dig = i;
               end
               if (dig < 0) begin
                  tests++;
                  fails++;
                  $display("FAIL sel_onehot: got %h expected one active-low bit", sel);
               end else begin
                  check($sformatf("seg_digit%0d", dig), 32'(seg), 32'(it.codes[dig]));
                  if (prev >= 0 && dig != prev) begin
                     check("scan_order", 32'(dig), 32'((prev + 1) % 6));
                     if (!first_run) check("dwell", 32'(run), 32'(DWELL));
                     first_run = 1'b0;
                     run       = 1;
                  end else begin
                     run++;
                  end
                  prev      = dig;
                  seen[dig] = 1'b1;
               end
            end
         end
         if (it.en) check("all_digits", 32'(seen), 32'h3F);
         done_cnt++;
      end
   end

   initial begin
      logic [5:0][7:0] pre;
      sys_rst_n = 1'b0;
      data      = 20'd123456;
      point     = '0;
      sign      = 1'b0;
      seg_en    = 1'b1;
      repeat (3) @(posedge sys_clk);
      #1;
      check("reset_sel", 32'(sel), 32'h3F);
      check("reset_seg", 32'(seg), 32'hFF);

      // Abort in the middle of SHIFT, then time the first LOAD from release
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      repeat (10) @(posedge sys_clk);
      #1;
      sys_rst_n = 1'b0;
      #1;
      check("midshift_rst_sel", 32'(sel), 32'h3F);
      check("midshift_rst_seg", 32'(seg), 32'hFF);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      pre = ref_codes(20'd0, 6'd0, 1'b0);
      repeat (22) @(posedge sys_clk);
      #1;
      check("pre_load_sel", 32'(sel), 32'h2F);
      check("pre_load_seg", 32'(seg), 32'(pre[4]));
      @(posedge sys_clk);
      #1;
      check("post_load_sel", 32'(sel), 32'h2F);
      check("post_load_seg", 32'(seg), 32'hA4);

      run_item(20'd123456, 6'b000000, 1'b0);
      run_item(20'hFFFFF,  6'b000000, 1'b0);
      run_item(20'd8,      6'b000010, 1'b1);
      run_item(20'd8,      6'b000000, 1'b1);
      run_item(20'd0,      6'b000000, 1'b0);
      run_item(20'd999999, 6'b100001, 1'b1);
      run_item(20'd1000000, 6'b000000, 1'b1);
      run_item(20'd100000, 6'b000000, 1'b1);

      // Display disable masks the pins; scan keeps going underneath
      @(negedge sys_clk);
      seg_en = 1'b0;
      push_item(1'b0, '0);
      @(negedge sys_clk);
      seg_en = 1'b1;
      push_item(1'b1, ref_codes(data, point, sign));

      for (int k = 0; k < 10; k++) begin
         logic [19:0] d;
         d = ($urandom_range(0, 3) == 0) ? 20'($urandom_range(0, 999)) : 20'($urandom);
         run_item(d, 6'($urandom), 1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
